// File: rtl/dbg_pkg.sv
// -----------------------------------------------------------------------------
// dbg_pkg
// Shared definitions for the debug-display sequencer:
//   - seq_state_t : sequencer FSM states (IDLE, REQ, WAIT)
//   - DISP_BLANK  : all-ones display word (every segment off)
//   - onehot_decode() : one-hot validity check plus index encode of a
//     channel-select vector (zero-extended to MAX_CH bits by the caller)
// -----------------------------------------------------------------------------
package dbg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } seq_state_t;

    // Wide enough for any sensible display word; users slice the low bits.
    localparam int                    MAX_DISP_W = 256;
    localparam logic [MAX_DISP_W-1:0] DISP_BLANK = '1;

    // Upper bound on probe channels handled by onehot_decode().
    localparam int MAX_CH = 32;

    typedef struct packed {
        logic        valid;   // exactly one bit of the select was set
        logic [31:0] idx;     // position of that bit (meaningless if !valid)
    } ch_sel_t;

    function automatic ch_sel_t onehot_decode(input logic [MAX_CH-1:0] sel);
        ch_sel_t     r;
        int unsigned hits;
        r.valid = 1'b0;
        r.idx   = '0;
        hits    = 0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (sel[i]) begin
                hits++;
                r.idx = 32'(i);
            end
        end
        r.valid = (hits == 1);
        return r;
    endfunction

endpackage

// File: rtl/dbg_step_gen.sv
// -----------------------------------------------------------------------------
// dbg_step_gen
// Generates the single-cycle step event for the display sequencer.
//   - free-running prescaler; tick = rising edge of bit DIV_SLOW or DIV_FAST
//   - 2-flop synchroniser + rising-edge detect on the asynchronous button
//   - step_o = manual_i ? btn_pulse : (run_i & tick)
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   run_i       : enable tick-driven stepping
//   manual_i    : 1 = step on button only, 0 = step on tick
//   slow_i      : select DIV_SLOW tick, else DIV_FAST
//   step_btn_i  : asynchronous push button
//   step_o      : one-cycle step event
// -----------------------------------------------------------------------------
module dbg_step_gen #(
    parameter int DIV_W    = 28,
    parameter int DIV_FAST = 25,
    parameter int DIV_SLOW = 27
) (
    input  logic clk,
    input  logic rstn,
    input  logic run_i,
    input  logic manual_i,
    input  logic slow_i,
    input  logic step_btn_i,
    output logic step_o
);

    logic [DIV_W-1:0] div_q;
    logic             div_bit;
    logic             div_bit_q;
    logic             tick;
    logic [1:0]       btn_sync_q;
    logic             btn_q;
    logic             btn_pulse;

    // Switching slow_i mid-count may add or drop one tick; harmless here.
    assign div_bit   = slow_i ? div_q[DIV_SLOW] : div_q[DIV_FAST];
    assign tick      = div_bit & ~div_bit_q;
    assign btn_pulse = btn_sync_q[1] & ~btn_q;
    assign step_o    = manual_i ? btn_pulse : (run_i & tick);

    // NOTE: non-blocking assignments so every flop here samples the values
    // from before the edge; blocking would collapse the synchroniser chain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q      <= '0;
            div_bit_q  <= 1'b0;
            btn_sync_q <= '0;
            btn_q      <= 1'b0;
        end else begin
            div_q      <= div_q + DIV_W'(1);
            div_bit_q  <= div_bit;
            btn_sync_q <= {btn_sync_q[0], step_btn_i};
            btn_q      <= btn_sync_q[1];
        end
    end

endmodule

// File: rtl/dbg_disp_seq.sv
// -----------------------------------------------------------------------------
// dbg_disp_seq
// Debug-display sequencer: on each step event reads the next word of the
// selected probe channel through a req/valid handshake (with timeout) and
// holds it for the seven-segment display driver.
// Ports:
//   clk, rstn    : clock, asynchronous active-low reset
//   ch_sel_i     : one-hot channel select
//   ch_last_i    : per-channel last address, channel i at [i*ADDR_W +: ADDR_W]
//   run_i, manual_i, slow_i, step_btn_i : step source controls
//   rd_req_o, rd_ch_o, rd_addr_o         : one-cycle read request
//   rd_data_i, rd_valid_i                : read response
//   disp_data_o, disp_addr_o             : captured word and its address
//   busy_o       : read in flight (REQ/WAIT)
//   timeout_o    : sticky, a read timed out
//   overrun_o    : sticky, a step arrived while busy and was dropped
// -----------------------------------------------------------------------------
module dbg_disp_seq
    import dbg_pkg::*;
#(
    parameter int  DISP_W   = 64,
    parameter int  NUM_CH   = 4,
    parameter int  ADDR_W   = 6,
    parameter int  DIV_W    = 28,
    parameter int  DIV_FAST = 25,
    parameter int  DIV_SLOW = 27,
    parameter int  TIMEOUT  = 15,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_CH-1:0]        ch_sel_i,
    input  logic [NUM_CH*ADDR_W-1:0] ch_last_i,
    input  logic                     run_i,
    input  logic                     manual_i,
    input  logic                     slow_i,
    input  logic                     step_btn_i,
    output logic                     rd_req_o,
    output logic [CH_W-1:0]          rd_ch_o,
    output logic [ADDR_W-1:0]        rd_addr_o,
    input  logic [DISP_W-1:0]        rd_data_i,
    input  logic                     rd_valid_i,
    output logic [DISP_W-1:0]        disp_data_o,
    output logic [ADDR_W-1:0]        disp_addr_o,
    output logic                     busy_o,
    output logic                     timeout_o,
    output logic                     overrun_o
);

    localparam int                TMR_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0]  TMR_MAX = TMR_W'(TIMEOUT);
    localparam logic [DISP_W-1:0] BLANK   = DISP_BLANK[DISP_W-1:0];

    seq_state_t        state;
    logic [TMR_W-1:0]  timer;
    logic [ADDR_W-1:0] addr_q [NUM_CH];

    logic              step_evt;
    logic [MAX_CH-1:0] sel_pad;
    ch_sel_t           sel_info;
    logic [CH_W-1:0]   sel_ch;
    logic              step_ok;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] cur_last;
    logic [ADDR_W-1:0] next_addr;

    dbg_step_gen #(
        .DIV_W    (DIV_W),
        .DIV_FAST (DIV_FAST),
        .DIV_SLOW (DIV_SLOW)
    ) u_step (
        .clk        (clk),
        .rstn       (rstn),
        .run_i      (run_i),
        .manual_i   (manual_i),
        .slow_i     (slow_i),
        .step_btn_i (step_btn_i),
        .step_o     (step_evt)
    );

    // NOTE: assign a default before the partial write so always_comb stays
    // purely combinational; a bit left unassigned on some path infers a latch.
    always_comb begin
        sel_pad             = '0;
        sel_pad[NUM_CH-1:0] = ch_sel_i;
    end

    assign sel_info = onehot_decode(sel_pad);
    assign sel_ch   = CH_W'(sel_info.idx);
    // Steps on an invalid select are fully ignored, including for overrun.
    assign step_ok  = step_evt & sel_info.valid;

    // Advance uses the latched channel; >= also wraps an address left
    // beyond a last value that was lowered at runtime.
    assign cur_addr  = addr_q[rd_ch_o];
    assign cur_last  = ch_last_i[rd_ch_o*ADDR_W +: ADDR_W];
    assign next_addr = (cur_addr >= cur_last) ? '0 : cur_addr + ADDR_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            timer       <= '0;
            rd_req_o    <= 1'b0;
            rd_ch_o     <= '0;
            rd_addr_o   <= '0;
            disp_data_o <= BLANK;
            disp_addr_o <= '0;
            busy_o      <= 1'b0;
            timeout_o   <= 1'b0;
            overrun_o   <= 1'b0;
            // NOTE: this small address array must start at zero after reset,
            // so it is built from resettable flops rather than a RAM.
            for (int i = 0; i < NUM_CH; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            if (step_ok && state != IDLE) begin
                overrun_o <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (step_ok) begin
                        rd_ch_o   <= sel_ch;
                        rd_addr_o <= addr_q[sel_ch];
                        rd_req_o  <= 1'b1;
                        busy_o    <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    rd_req_o <= 1'b0;
                    timer    <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // Valid has priority over a timeout in the same cycle.
                    if (rd_valid_i || timer == TMR_MAX) begin
                        disp_data_o      <= rd_valid_i ? rd_data_i : BLANK;
                        disp_addr_o      <= rd_addr_o;
                        addr_q[rd_ch_o]  <= next_addr;
                        busy_o           <= 1'b0;
                        state            <= IDLE;
                        if (!rd_valid_i) begin
                            timeout_o <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: begin
                    rd_req_o <= 1'b0;
                    busy_o   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_disp_seq.sv
// -----------------------------------------------------------------------------
// tb_dbg_disp_seq
// Directed bench for dbg_disp_seq: auto stepping, manual button stepping,
// per-channel resume, read timeout, invalid select / overrun and reset during
// an in-flight read. A responder answers each request one cycle after
// rd_req_o with {58'h0, rd_addr_o} while resp_en is set.
// -----------------------------------------------------------------------------
module tb_dbg_disp_seq;

    localparam int DISP_W = 64;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 6;
    localparam int CH_W   = 2;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic [NUM_CH-1:0]        ch_sel_i;
    logic [NUM_CH*ADDR_W-1:0] ch_last_i;
    logic                     run_i;
    logic                     manual_i;
    logic                     slow_i;
    logic                     step_btn_i;
    logic                     rd_req_o;
    logic [CH_W-1:0]          rd_ch_o;
    logic [ADDR_W-1:0]        rd_addr_o;
    logic [DISP_W-1:0]        rd_data_i;
    logic                     rd_valid_i;
    logic [DISP_W-1:0]        disp_data_o;
    logic [ADDR_W-1:0]        disp_addr_o;
    logic                     busy_o;
    logic                     timeout_o;
    logic                     overrun_o;

    int   errors     = 0;
    int   checks     = 0;
    int   req_count  = 0;
    int   long_pulse = 0;
    logic req_prev   = 1'b0;
    int   req_ch_q[$];
    int   req_addr_q[$];
    logic resp_en     = 1'b0;
    logic force_valid = 1'b0;

    dbg_disp_seq #(
        .DISP_W   (DISP_W),
        .NUM_CH   (NUM_CH),
        .ADDR_W   (ADDR_W),
        .DIV_W    (28),
        .DIV_FAST (2),
        .DIV_SLOW (3),
        .TIMEOUT  (15)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .ch_sel_i    (ch_sel_i),
        .ch_last_i   (ch_last_i),
        .run_i       (run_i),
        .manual_i    (manual_i),
        .slow_i      (slow_i),
        .step_btn_i  (step_btn_i),
        .rd_req_o    (rd_req_o),
        .rd_ch_o     (rd_ch_o),
        .rd_addr_o   (rd_addr_o),
        .rd_data_i   (rd_data_i),
        .rd_valid_i  (rd_valid_i),
        .disp_data_o (disp_data_o),
        .disp_addr_o (disp_addr_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample point: just after the falling edge, well away from posedge.
    task automatic step_cyc();
        @(negedge clk);
        #1;
    endtask

    // Request monitor: logs every request and counts pulses longer than 1.
    always @(negedge clk) begin
        if (rd_req_o) begin
            req_count++;
            req_ch_q.push_back(int'(rd_ch_o));
            req_addr_q.push_back(int'(rd_addr_o));
            if (req_prev) long_pulse++;
        end
        req_prev = rd_req_o;
    end

    // Responder: valid in the first WAIT cycle (busy and no request).
    initial begin
        rd_valid_i = 1'b0;
        rd_data_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            rd_valid_i = force_valid | (resp_en & busy_o & ~rd_req_o);
            rd_data_i  = force_valid ? 64'hDEAD_BEEF_0000_1234 : {58'h0, rd_addr_o};
        end
    end

    task automatic do_reset();
        rstn        = 1'b0;
        run_i       = 1'b0;
        manual_i    = 1'b0;
        slow_i      = 1'b0;
        step_btn_i  = 1'b0;
        resp_en     = 1'b0;
        force_valid = 1'b0;
        ch_sel_i    = 4'b0001;
        repeat (3) step_cyc();
        rstn = 1'b1;
        step_cyc();
    endtask

    task automatic wait_req(int target, string tag);
        int n = 0;
        while (req_count < target && n < 40) begin
            step_cyc();
            n++;
        end
        if (req_count < target) check(tag, 64'(req_count), 64'(target));
    endtask

    task automatic wait_idle(string tag);
        int n = 0;
        while (busy_o && n < 60) begin
            step_cyc();
            n++;
        end
        if (busy_o) check(tag, 64'(busy_o), 64'd0);
    endtask

    task automatic press(int width, int gap);
        step_btn_i = 1'b1;
        repeat (width) step_cyc();
        step_btn_i = 1'b0;
        repeat (gap) step_cyc();
    endtask

    int auto_exp[5]  = '{0, 1, 2, 0, 1};
    int res_ch[6]    = '{0, 0, 0, 2, 2, 0};
    int res_addr[6]  = '{0, 1, 2, 0, 1, 3};

    initial begin
        int base;
        ch_last_i = '0;

        // ---- reset state ----
        do_reset();
        check("rst_disp_data", disp_data_o, ONES);
        check("rst_disp_addr", 64'(disp_addr_o), 64'd0);
        check("rst_rd_req",    64'(rd_req_o), 64'd0);
        check("rst_rd_addr",   64'(rd_addr_o), 64'd0);
        check("rst_rd_ch",     64'(rd_ch_o), 64'd0);
        check("rst_busy",      64'(busy_o), 64'd0);
        check("rst_flags",     64'({timeout_o, overrun_o}), 64'd0);

        // ---- auto stepping on the fast tick ----
        ch_last_i = {18'd0, 6'd2};
        resp_en   = 1'b1;
        run_i     = 1'b1;
        base      = req_count;
        for (int k = 0; k < 5; k++) begin
            wait_req(base + k + 1, "auto_req_wait");
            wait_idle("auto_idle_wait");
            check("auto_disp_addr", 64'(disp_addr_o), 64'(auto_exp[k]));
            check("auto_disp_data", disp_data_o, 64'(auto_exp[k]));
        end
        run_i = 1'b0;
        repeat (20) step_cyc();
        check("auto_req_count", 64'(req_count - base), 64'd5);
        check("auto_pulse_len", 64'(long_pulse), 64'd0);
        check("auto_overrun",   64'(overrun_o), 64'd0);

        // ---- manual button stepping ----
        do_reset();
        manual_i  = 1'b1;
        ch_last_i = {18'd0, 6'd2};
        resp_en   = 1'b1;
        base      = req_count;
        press(20, 10);
        check("man_cnt1",  64'(req_count - base), 64'd1);
        check("man_addr1", 64'(disp_addr_o), 64'd0);
        press(20, 10);
        check("man_cnt2",  64'(req_count - base), 64'd2);
        check("man_addr2", 64'(disp_addr_o), 64'd1);
        press(60, 10);
        check("man_hold_cnt",  64'(req_count - base), 64'd3);
        check("man_hold_addr", 64'(disp_addr_o), 64'd2);

        // ---- per-channel resume ----
        do_reset();
        manual_i  = 1'b1;
        resp_en   = 1'b1;
        ch_last_i = {6'd0, 6'd5, 6'd0, 6'd7};
        req_ch_q.delete();
        req_addr_q.delete();
        base = req_count;
        ch_sel_i = 4'b0001;
        repeat (3) press(4, 8);
        ch_sel_i = 4'b0100;
        repeat (2) press(4, 8);
        ch_sel_i = 4'b0001;
        press(4, 8);
        check("res_count", 64'(req_count - base), 64'd6);
        for (int i = 0; i < 6 && i < req_ch_q.size(); i++) begin
            check("res_ch",   64'(req_ch_q[i]),   64'(res_ch[i]));
            check("res_addr", 64'(req_addr_q[i]), 64'(res_addr[i]));
        end
        check("res_disp_addr", 64'(disp_addr_o), 64'd3);

        // ---- timeout ----
        do_reset();
        manual_i  = 1'b1;
        ch_last_i = {18'd0, 6'd3};
        resp_en   = 1'b1;
        press(4, 8);
        check("to_pre_data", disp_data_o, 64'd0);
        resp_en    = 1'b0;
        base       = req_count;
        step_btn_i = 1'b1;
        wait_req(base + 1, "to_req_wait");
        step_btn_i = 1'b0;
        check("to_rd_addr", 64'(rd_addr_o), 64'd1);
        repeat (16) step_cyc();
        check("to_early_flag", 64'(timeout_o), 64'd0);
        check("to_early_busy", 64'(busy_o), 64'd1);
        step_cyc();
        check("to_flag",      64'(timeout_o), 64'd1);
        check("to_busy",      64'(busy_o), 64'd0);
        check("to_disp_data", disp_data_o, ONES);
        check("to_disp_addr", 64'(disp_addr_o), 64'd1);
        resp_en = 1'b1;
        repeat (4) step_cyc();
        press(4, 8);
        check("to_after_addr", 64'(disp_addr_o), 64'd2);
        check("to_after_data", disp_data_o, 64'd2);
        check("to_sticky",     64'(timeout_o), 64'd1);

        // ---- invalid select, then overrun ----
        do_reset();
        manual_i  = 1'b1;
        ch_last_i = {18'd0, 6'd3};
        resp_en   = 1'b1;
        press(4, 8);
        press(4, 8);
        check("inv_pre_data", disp_data_o, 64'd1);
        base     = req_count;
        ch_sel_i = 4'b0011;
        repeat (2) press(4, 8);
        ch_sel_i = 4'b0000;
        press(4, 8);
        check("inv_req_count", 64'(req_count - base), 64'd0);
        check("inv_disp_data", disp_data_o, 64'd1);
        check("inv_disp_addr", 64'(disp_addr_o), 64'd1);
        check("inv_overrun",   64'(overrun_o), 64'd0);

        ch_sel_i   = 4'b0001;
        resp_en    = 1'b0;
        base       = req_count;
        step_btn_i = 1'b1;
        wait_req(base + 1, "ovr_req_wait");
        step_btn_i = 1'b0;
        repeat (3) step_cyc();
        press(4, 4);
        check("ovr_flag", 64'(overrun_o), 64'd1);
        wait_idle("ovr_idle_wait");
        repeat (4) step_cyc();
        check("ovr_req_count", 64'(req_count - base), 64'd1);
        check("ovr_timeout",   64'(timeout_o), 64'd1);

        // ---- reset during WAIT ----
        do_reset();
        manual_i  = 1'b1;
        ch_last_i = {18'd0, 6'd3};
        resp_en   = 1'b1;
        press(4, 8);
        resp_en    = 1'b0;
        base       = req_count;
        step_btn_i = 1'b1;
        wait_req(base + 1, "rw_req_wait");
        step_btn_i = 1'b0;
        repeat (2) step_cyc();
        check("rw_busy_pre", 64'(busy_o), 64'd1);
        rstn        = 1'b0;
        force_valid = 1'b1;
        repeat (3) step_cyc();
        check("rw_in_rst_data", disp_data_o, ONES);
        check("rw_in_rst_busy", 64'(busy_o), 64'd0);
        rstn = 1'b1;
        repeat (3) step_cyc();
        force_valid = 1'b0;
        check("rw_disp_data", disp_data_o, ONES);
        check("rw_disp_addr", 64'(disp_addr_o), 64'd0);
        check("rw_rd_addr",   64'(rd_addr_o), 64'd0);
        check("rw_busy",      64'(busy_o), 64'd0);
        check("rw_req",       64'(rd_req_o), 64'd0);
        check("rw_flags",     64'({timeout_o, overrun_o}), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
